// File: rtl/oled_init_sequencer.sv
// OLED (SSD1306-class) init/pixel feeder for an I2C write master.
// Sends a fixed 25-byte command ROM and then streams pixel bytes, one transaction at a time, with retry on NACK or timeout.
module oled_init_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h3C,
  parameter int         POWERUP_CYCLES = 100000,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         RETRY_MAX      = 3
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       enable,
  output logic [6:0] slave_addr,
  output logic       read_write,
  output logic [7:0] control_frame,
  output logic [7:0] reg_addr,
  output logic [7:0] master_data,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       init_done,
  output logic       error,
  output logic [4:0] cmd_index
);

  localparam logic [2:0] PWR_WAIT = 3'd0;
  localparam logic [2:0] CMD_LOAD = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT     = 3'd3;
  localparam logic [2:0] FAIL     = 3'd4;
  localparam logic [2:0] NEXT     = 3'd5;
  localparam logic [2:0] READY    = 3'd6;
  localparam logic [2:0] HALT     = 3'd7;

  localparam int PWR_W = (POWERUP_CYCLES < 2) ? 1 : $clog2(POWERUP_CYCLES + 1);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(POWERUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);
  localparam logic [4:0]       LAST_CMD  = 5'd24;

  logic [2:0]       state;
  logic [PWR_W-1:0] pwr_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             tmo_hit;

  function automatic logic [7:0] cmd_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  cmd_rom = 8'hAE;
      5'd1:  cmd_rom = 8'hD5;
      5'd2:  cmd_rom = 8'h80;
      5'd3:  cmd_rom = 8'hA8;
      5'd4:  cmd_rom = 8'h3F;
      5'd5:  cmd_rom = 8'hD3;
      5'd6:  cmd_rom = 8'h00;
      5'd7:  cmd_rom = 8'h40;
      5'd8:  cmd_rom = 8'h8D;
      5'd9:  cmd_rom = 8'h14;
      5'd10: cmd_rom = 8'h20;
      5'd11: cmd_rom = 8'h00;
      5'd12: cmd_rom = 8'hA1;
      5'd13: cmd_rom = 8'hC8;
      5'd14: cmd_rom = 8'hDA;
      5'd15: cmd_rom = 8'h12;
      5'd16: cmd_rom = 8'h81;
      5'd17: cmd_rom = 8'hCF;
      5'd18: cmd_rom = 8'hD9;
      5'd19: cmd_rom = 8'hF1;
      5'd20: cmd_rom = 8'hDB;
      5'd21: cmd_rom = 8'h40;
      5'd22: cmd_rom = 8'hA4;
      5'd23: cmd_rom = 8'hA6;
      default: cmd_rom = 8'hAF;
    endcase
  endfunction

  assign enable     = (state == ISSUE);
  assign pix_ready  = (state == READY);
  assign slave_addr = SLAVE_ADDR;
  assign read_write = 1'b0;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state         <= PWR_WAIT;
      pwr_cnt       <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      cmd_index     <= '0;
      reg_addr      <= '0;
      master_data   <= '0;
      control_frame <= '0;
      init_done     <= 1'b0;
      error         <= 1'b0;
    end else begin
      // The timeout window spans ISSUE and WAIT; it saturates so a late busy still fails promptly.
      if ((state == ISSUE || state == WAIT) && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == PWR_LAST) state <= CMD_LOAD;
          else pwr_cnt <= pwr_cnt + 1'b1;
        end
        CMD_LOAD: begin
          reg_addr      <= cmd_rom(cmd_index);
          control_frame <= 8'h00;
          retry_cnt     <= '0;
          tmo_cnt       <= '0;
          state         <= ISSUE;
        end
        ISSUE: begin
          if (i2c_busy) state <= WAIT;
          else if (tmo_hit) state <= FAIL;
        end
        WAIT: begin
          if (i2c_done) state <= i2c_nack ? FAIL : NEXT;
          else if (tmo_hit) state <= FAIL;
        end
        FAIL: begin
          if (retry_cnt < RTY_LIMIT) begin
            retry_cnt <= retry_cnt + 1'b1;
            tmo_cnt   <= '0;
            state     <= ISSUE;
          end else begin
            error <= 1'b1;
            state <= HALT;
          end
        end
        NEXT: begin
          if (init_done) state <= READY;
          else if (cmd_index == LAST_CMD) begin
            init_done <= 1'b1;
            state     <= READY;
          end else begin
            cmd_index <= cmd_index + 1'b1;
            state     <= CMD_LOAD;
          end
        end
        READY: begin
          if (pix_valid) begin
            master_data   <= pix_data;
            control_frame <= 8'h40;
            retry_cnt     <= '0;
            tmo_cnt       <= '0;
            state         <= ISSUE;
          end
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Scoreboard bench: an I2C master model records each issued transaction, a monitor compares it to the expected queue.
module tb_oled_init_sequencer;
  localparam int PWR = 10, TMO = 200, RMAX = 3, BUSY_LEN = 3;

  logic       CLK = 1'b0, NRST = 1'b0;
  logic       i2c_busy = 1'b0, i2c_done = 1'b0, i2c_nack = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       enable, read_write, pix_ready, init_done, error;
  logic [6:0] slave_addr;
  logic [7:0] control_frame, reg_addr, master_data;
  logic [4:0] cmd_index;

  oled_init_sequencer #(
    .SLAVE_ADDR(7'h3C), .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX)
  ) dut (
    .CLK(CLK), .NRST(NRST), .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .enable(enable), .slave_addr(slave_addr), .read_write(read_write),
    .control_frame(control_frame), .reg_addr(reg_addr), .master_data(master_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .init_done(init_done), .error(error), .cmd_index(cmd_index)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                            8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                            8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int busy_delay_once = 0, nack_idx = -1, nack_left = 0;
  int done_cnt = 0, last_done_edge = 0;
  int m_state = 0, m_cnt = 0;
  bit m_first = 1'b0;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic fail_bound(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_cmds(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back({8'h00, rom[i]});
  endtask

  task automatic raise_busy();
    i2c_busy = 1'b1;
    obs_q.push_back({control_frame, (control_frame == 8'h40) ? master_data : reg_addr});
    m_cnt   = BUSY_LEN;
    m_first = 1'b1;
    m_state = 2;
  endtask

  // I2C master model: optional busy delay, fixed busy length, scripted NACKs.
  initial forever begin
    @(posedge CLK);
    #1;
    if (!NRST) begin
      m_state = 0; i2c_busy = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    end else begin
      case (m_state)
        0: if (enable) begin
          m_cnt = (busy_delay_once > 1) ? busy_delay_once - 1 : 0;
          busy_delay_once = 0;
          if (m_cnt == 0) raise_busy();
          else m_state = 1;
        end
        1: begin
          check("enable_held_until_busy", enable, 1);
          m_cnt--;
          if (m_cnt == 0) raise_busy();
        end
        2: begin
          if (m_first) begin
            check("enable_drop_after_busy", enable, 0);
            m_first = 1'b0;
          end
          m_cnt--;
          if (m_cnt == 0) begin
            i2c_busy = 1'b0;
            i2c_done = 1'b1;
            i2c_nack = (nack_left > 0 && control_frame == 8'h00 && int'(cmd_index) == nack_idx);
            if (i2c_nack) nack_left--;
            done_cnt++;
            last_done_edge = cyc + 1;
            m_state = 3;
          end
        end
        default: begin
          i2c_done = 1'b0; i2c_nack = 1'b0; m_state = 0;
        end
      endcase
    end
  end

  // Monitor: every observed transaction is compared against the head of the expected queue.
  initial begin
    logic [15:0] o;
    forever begin
      @(negedge CLK);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_txn: got cf/byte %h, expected none", o);
        end else check("txn_cf_byte", o, exp_q.pop_front());
      end
    end
  end

  task automatic wait_flag(input string nm, input bit want_err);
    bit found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick(1);
      if (want_err ? error : init_done) found = 1'b1;
    end
    if (!found) fail_bound(nm);
  endtask

  task automatic send_pix(input logic [7:0] d, input string nm);
    bit ok = 1'b0;
    pix_valid = 1'b1;
    pix_data  = d;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (pix_ready) ok = 1'b1;
      else tick(1);
    end
    if (!ok) fail_bound(nm);
    else begin
      tick(1);
      check({nm, "_ready_drop"}, pix_ready, 0);
      check({nm, "_master_data"}, master_data, d);
      check({nm, "_cf"}, control_frame, 8'h40);
    end
  endtask

  initial begin
    int d0;
    bit seen_en, found;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    bit seen_en, found;
    // Reset values
    NRST = 1'b0;
    tick(2);
    check("rst_enable", enable, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_error", error, 0);
    check("rst_read_write", read_write, 0);
    check("rst_cmd_index", cmd_index, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_master_data", master_data, 0);
    check("rst_control_frame", control_frame, 0);
    check("rst_slave_addr", slave_addr, 7'h3C);

    // Full init sequence, first transaction with a 50-cycle busy delay
    busy_delay_once = 50;
    push_cmds(0, 24);
    NRST = 1'b1;
    wait_flag("init_done_wait", 1'b0);
    check("init_done_latency", cyc, last_done_edge + 1);
    check("pix_ready_after_init", pix_ready, 1);
    check("cmd_index_hold_24", cmd_index, 24);
    check("init_queue_drained", exp_q.size(), 0);

    // Back-to-back pixel bytes with pix_valid held
    exp_q.push_back({8'h40, 8'hA5});
    exp_q.push_back({8'h40, 8'h3C});
    send_pix(8'hA5, "pix0");
    d0 = done_cnt;
    send_pix(8'h3C, "pix1");
    check("pix1_accept_after_done", done_cnt, d0 + 1);
    pix_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (pix_ready) found = 1'b1;
    end
    if (!found) fail_bound("pix_ready_return");
    tick(3);
    check("pix_queue_drained", exp_q.size(), 0);
    check("reg_addr_hold_data", reg_addr, 8'hAF);
    check("cmd_index_no_wrap", cmd_index, 24);

    // NACK twice on command index 3, then ACK
    NRST = 1'b0;
    tick(2);
    nack_idx = 3; nack_left = 2;
    push_cmds(0, 3);
    exp_q.push_back({8'h00, 8'hA8});
    exp_q.push_back({8'h00, 8'hA8});
    push_cmds(4, 24);
    NRST = 1'b1;
    wait_flag("nack3_init_wait", 1'b0);
    check("nack3_error", error, 0);
    check("nack3_used", nack_left, 0);
    check("nack3_queue_drained", exp_q.size(), 0);

    // NACK every attempt of index 0: four attempts then sticky error
    NRST = 1'b0;
    tick(2);
    nack_idx = 0; nack_left = 100;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'h00, 8'hAE});
    NRST = 1'b1;
    wait_flag("error_wait", 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("halt_enable", enable, 0);
      check("halt_pix_ready", pix_ready, 0);
      check("halt_init_done", init_done, 0);
      check("halt_error", error, 1);
    end
    check("halt_attempts", nack_left, 96);
    check("halt_queue_drained", exp_q.size(), 0);

    // Reset during WAIT of command index 10, then restart from AE
    NRST = 1'b0;
    tick(2);
    check("rst_clears_error", error, 0);
    nack_idx = -1; nack_left = 0;
    push_cmds(0, 10);
    NRST = 1'b1;
    seen_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (cmd_index == 5'd10 && seen_en && !enable) found = 1'b1;
      if (cmd_index == 5'd10 && enable) seen_en = 1'b1;
    end
    if (!found) fail_bound("idx10_wait");
    #1;
    NRST = 1'b0;
    #1;
    check("midrst_enable", enable, 0);
    check("midrst_cmd_index", cmd_index, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_reg_addr", reg_addr, 0);
    tick(3);
    check("midrst_queue_drained", exp_q.size(), 0);
    push_cmds(0, 24);
    NRST = 1'b1;
    wait_flag("restart_init_wait", 1'b0);
    tick(2);
    check("restart_queue_drained", exp_q.size(), 0);
    check("restart_init_done", init_done, 1);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
